// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding and default window/timeout.
package mem_bus_pkg;
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] INT_RD   = 2'd1;
  localparam logic [1:0] EXT_WAIT = 2'd2;
  localparam logic [1:0] EXT_DONE = 2'd3;

  localparam logic [31:0] DEF_INT_LOWER = 32'h800;
  localparam logic [31:0] DEF_INT_UPPER = 32'hBFF;
  localparam int          DEF_TIMEOUT   = 16;
  localparam int          CNT_W         = 16;
endpackage

// File: rtl/mem_bus_controller_addr_window_cmp.sv
// addr_window_cmp: inclusive unsigned address window test.
module addr_window_cmp (
  input  logic [31:0] Address,
  input  logic [31:0] lower,
  input  logic [31:0] upper,
  output logic        hit
);
  assign hit = (Address >= lower) && (Address <= upper);
endmodule

// File: rtl/mem_bus_controller.sv
// mem_bus_controller: routes CPU accesses to internal RAM or
// to an external handshaked memory with a wait timeout.
module mem_bus_controller
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] INT_LOWER = DEF_INT_LOWER,
  parameter logic [31:0] INT_UPPER = DEF_INT_UPPER,
  parameter int          TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] WrData,
  input  logic        Rd,
  input  logic        Wr,
  output logic        Stall,
  output logic [31:0] RdData,
  output logic [9:0]  IntAddr,
  output logic        IntWe,
  output logic [31:0] IntWrData,
  input  logic [31:0] IntRdData,
  output logic        ExtReq,
  output logic        ExtWe,
  output logic [31:0] ExtAddr,
  output logic [31:0] ExtWrData,
  input  logic        ExtAck,
  input  logic [31:0] ExtRdData,
  output logic        BusError
);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rd_q;
  logic             hit;
  logic             idle;
  logic             waiting;
  logic             acc_wr_int;
  logic             acc_rd_int;
  logic             acc_ext;
  logic             to_hit;

  addr_window_cmp u_win (
    .Address (Address),
    .lower   (INT_LOWER),
    .upper   (INT_UPPER),
    .hit     (hit)
  );

  assign idle       = (state == IDLE);
  assign waiting    = (state == EXT_WAIT);
  assign acc_wr_int = idle & hit & Wr;
  assign acc_rd_int = idle & hit & Rd & ~Wr;
  assign acc_ext    = idle & ~hit & (Rd | Wr);
  // an ack in the last allowed cycle wins over the timeout
  assign to_hit     = waiting & ~ExtAck & (cnt == TO_LAST);

  assign Stall     = ~Reset & (acc_rd_int | acc_ext | waiting);
  assign IntWe     = ~Reset & acc_wr_int;
  assign BusError  = ~Reset & to_hit;
  assign IntAddr   = Address[11:2] - INT_LOWER[11:2];
  assign IntWrData = WrData;
  assign RdData    = (state == INT_RD) ? IntRdData : rd_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_q      <= '0;
      ExtReq    <= 1'b0;
      ExtWe     <= 1'b0;
      ExtAddr   <= '0;
      ExtWrData <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc_ext) begin
            ExtAddr   <= Address;
            ExtWrData <= WrData;
            ExtWe     <= Wr;
            ExtReq    <= 1'b1;
            cnt       <= '0;
            state     <= EXT_WAIT;
          end else if (acc_rd_int) begin
            state <= INT_RD;
          end
        end
        INT_RD: state <= IDLE;
        EXT_WAIT: begin
          cnt <= cnt + 1'b1;
          if (ExtAck) begin
            rd_q   <= ExtRdData;
            ExtReq <= 1'b0;
            ExtWe  <= 1'b0;
            state  <= EXT_DONE;
          end else if (to_hit) begin
            rd_q   <= '0;
            ExtReq <= 1'b0;
            ExtWe  <= 1'b0;
            state  <= EXT_DONE;
          end
        end
        EXT_DONE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_controller.sv
// tb_mem_bus_controller: transaction-level model with a
// per-cycle compare process and directed vectors.
module tb_mem_bus_controller;
  localparam logic [31:0] LO = 32'h800;
  localparam logic [31:0] HI = 32'hBFF;
  localparam int          TO = 16;

  logic        CLK;
  logic        Reset;
  logic [31:0] Address;
  logic [31:0] WrData;
  logic        Rd;
  logic        Wr;
  logic        Stall;
  logic [31:0] RdData;
  logic [9:0]  IntAddr;
  logic        IntWe;
  logic [31:0] IntWrData;
  logic [31:0] IntRdData;
  logic        ExtReq;
  logic        ExtWe;
  logic [31:0] ExtAddr;
  logic [31:0] ExtWrData;
  logic        ExtAck;
  logic [31:0] ExtRdData;
  logic        BusError;

  mem_bus_controller #(
    .INT_LOWER (LO),
    .INT_UPPER (HI),
    .TIMEOUT   (TO)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Address   (Address),
    .WrData    (WrData),
    .Rd        (Rd),
    .Wr        (Wr),
    .Stall     (Stall),
    .RdData    (RdData),
    .IntAddr   (IntAddr),
    .IntWe     (IntWe),
    .IntWrData (IntWrData),
    .IntRdData (IntRdData),
    .ExtReq    (ExtReq),
    .ExtWe     (ExtWe),
    .ExtAddr   (ExtAddr),
    .ExtWrData (ExtWrData),
    .ExtAck    (ExtAck),
    .ExtRdData (ExtRdData),
    .BusError  (BusError)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors;
  int miscompares;

  bit          exp_on;
  logic        e_stall, e_intwe, e_extreq, e_buserr;
  bit          c_rd, c_ia, c_ext, c_iwd;
  logic [31:0] e_rd, e_eaddr, e_ewd, e_iwd;
  logic [9:0]  e_ia;
  logic        e_ewe;

  task automatic chk1(string nm, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_int(logic [31:0] a);
    return (a >= LO) && (a <= HI);
  endfunction

  function automatic logic [9:0] word_idx(logic [31:0] a);
    return 10'((a - LO) / 4);
  endfunction

  always @(negedge CLK) begin
    if (exp_on) begin
      chk1("stall", Stall, e_stall);
      chk1("int_we", IntWe, e_intwe);
      chk1("ext_req", ExtReq, e_extreq);
      chk1("bus_error", BusError, e_buserr);
      if (c_rd) chk32("rd_data", RdData, e_rd);
      if (c_ia) chk32("int_addr", {22'b0, IntAddr}, {22'b0, e_ia});
      if (c_iwd) chk32("int_wr_data", IntWrData, e_iwd);
      if (c_ext) begin
        chk32("ext_addr", ExtAddr, e_eaddr);
        chk32("ext_wr_data", ExtWrData, e_ewd);
        chk1("ext_we", ExtWe, e_ewe);
      end
    end
  end

  task automatic set_idle();
    exp_on   = 1'b1;
    e_stall  = 1'b0;
    e_intwe  = 1'b0;
    e_extreq = 1'b0;
    e_buserr = 1'b0;
    c_rd     = 1'b0;
    c_ia     = 1'b0;
    c_ext    = 1'b0;
    c_iwd    = 1'b0;
  endtask

  // ack_at: EXT_WAIT cycle (1-based) in which ExtAck is raised; <1 = never
  task automatic txn(input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int ack_at, input logic [31:0] ad,
                     input logic [31:0] id, input bit pin_on,
                     input logic [9:0] pin_ia, input logic [31:0] pin_rd);
    bit internal;
    bit acked;
    internal = is_int(a);
    acked = 1'b0;
    @(posedge CLK); #1;
    Rd = rd; Wr = wr; Address = a; WrData = wd;
    IntRdData = id; ExtRdData = ad;
    set_idle();
    e_stall = !(internal && wr);
    e_intwe = internal && wr;
    c_ia = internal; e_ia = word_idx(a);
    c_iwd = internal && wr; e_iwd = wd;
    if (pin_on && internal) begin
      @(negedge CLK); #1;
      chk32("pin_int_addr", {22'b0, IntAddr}, {22'b0, pin_ia});
    end
    if (internal && !wr) begin
      @(posedge CLK); #1;
      set_idle();
      c_rd = 1'b1; e_rd = id;
      if (pin_on) begin
        @(negedge CLK); #1;
        chk32("pin_rd_data", RdData, pin_rd);
      end
    end else if (!internal) begin
      for (int k = 1; k <= TO && !acked; k++) begin
        @(posedge CLK); #1;
        ExtAck = (k == ack_at);
        acked = (k == ack_at);
        set_idle();
        e_stall = 1'b1; e_extreq = 1'b1;
        e_buserr = !acked && (k == TO);
        c_ext = 1'b1; e_eaddr = a; e_ewd = wd; e_ewe = wr;
      end
      @(posedge CLK); #1;
      ExtAck = 1'b0;
      set_idle();
      c_rd = rd && !wr;
      e_rd = acked ? ad : 32'h0;
      if (pin_on && rd && !wr) begin
        @(negedge CLK); #1;
        chk32("pin_rd_data", RdData, pin_rd);
      end
    end
    @(posedge CLK); #1;
    Rd = 1'b0; Wr = 1'b0;
    set_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vectors = 0; miscompares = 0; exp_on = 1'b0;
    Reset = 1'b1; Rd = 1'b0; Wr = 1'b0; Address = 32'h0;
    WrData = 32'h0; IntRdData = 32'h0; ExtAck = 1'b0;
    ExtRdData = 32'h0;
    set_idle(); exp_on = 1'b0;
    #12;
    chk1("rst_stall", Stall, 1'b0);
    chk1("rst_ext_req", ExtReq, 1'b0);
    chk1("rst_ext_we", ExtWe, 1'b0);
    chk1("rst_int_we", IntWe, 1'b0);
    chk1("rst_bus_error", BusError, 1'b0);
    chk32("rst_rd_data", RdData, 32'h0);
    chk32("rst_ext_addr", ExtAddr, 32'h0);
    chk32("rst_ext_wr_data", ExtWrData, 32'h0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    set_idle();

    txn(0, 1, 32'h800, 32'hA5A5A5A5, 0, 0, 0, 1, 10'd0, 0);
    txn(1, 0, 32'hBFC, 0, 0, 0, 32'h1234, 1, 10'd255, 32'h1234);
    txn(1, 0, 32'hC00, 0, 4, 32'hDEADBEEF, 0, 1, 0, 32'hDEADBEEF);
    txn(0, 1, 32'h7FC, 32'h0BADF00D, 0, 0, 0, 0, 0, 0);
    txn(1, 1, 32'h900, 32'h55AA55AA, 0, 0, 0, 1, 10'd64, 0);
    txn(1, 0, 32'h1000, 0, TO, 32'hCAFEF00D, 0, 1, 0, 32'hCAFEF00D);
    txn(0, 1, 32'hFFFFFFFC, 32'h13579BDF, 1, 32'h1, 0, 0, 0, 0);
    txn(1, 0, 32'hBFF, 0, 0, 0, 32'h87654321, 1, 10'd255, 32'h87654321);
    txn(1, 0, 32'h7FF, 0, 2, 32'h0F0F0F0F, 0, 0, 0, 0);
    txn(1, 0, 32'h4000, 0, 0, 32'hFFFF0000, 0, 1, 0, 32'h0);

    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      ExtAck = 1'b1; ExtRdData = 32'h11110000 + i;
      set_idle();
    end
    @(posedge CLK); #1;
    ExtAck = 1'b0;

    Rd = 1'b1; Address = 32'h2000;
    set_idle(); e_stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge CLK); #1;
      set_idle(); e_stall = 1'b1; e_extreq = 1'b1;
    end
    @(posedge CLK); #1;
    exp_on = 1'b0;
    Reset = 1'b1; Rd = 1'b0;
    #1;
    chk1("abort_ext_req", ExtReq, 1'b0);
    chk1("abort_stall", Stall, 1'b0);
    chk1("abort_bus_error", BusError, 1'b0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    ExtAck = 1'b1; ExtRdData = 32'h99999999;
    set_idle(); c_rd = 1'b1; e_rd = 32'h0;
    for (int i = 0; i < 4; i++) @(posedge CLK);
    #1;
    ExtAck = 1'b0;
    txn(1, 0, 32'hA00, 0, 0, 0, 32'h2468ACE0, 1, 10'd128, 32'h2468ACE0);

    @(posedge CLK); #1;
    exp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_bus_controller.md
MEM_BUS_CONTROLLER -- requirements
Module: mem_bus_controller

Interface
REQ-001 SHALL have parameter INT_LOWER, default 32'h800, first internal-memory byte address.
REQ-002 SHALL have parameter INT_UPPER, default 32'hBFF, last internal-memory byte address.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum cycles spent waiting for ExtAck.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Address  input  32  CPU access address, held stable while Stall=1.
REQ-007 SHALL have port WrData  input  32  CPU store data.
REQ-008 SHALL have ports Rd and Wr  input  1 each  CPU load and store requests.
REQ-009 SHALL have port Stall  output  1  CPU must hold its request and Address.
REQ-010 SHALL have port RdData  output  32  load result, valid in the cycle Stall falls for a read.
REQ-011 SHALL have ports IntAddr  output  10, IntWe  output  1, IntWrData  output  32, IntRdData  input  32  internal synchronous RAM, one-cycle read latency.
REQ-012 SHALL have ports ExtReq  output  1, ExtWe  output  1, ExtAddr  output  32, ExtWrData  output  32, ExtAck  input  1, ExtRdData  input  32  external memory handshake.
REQ-013 SHALL have port BusError  output  1  one-cycle pulse on external timeout.

Function
REQ-014 Address SHALL be internal iff INT_LOWER <= Address <= INT_UPPER (unsigned, both bounds inclusive); otherwise external.
REQ-015 IntAddr SHALL equal Address[11:2] - INT_LOWER[11:2] (word index, 0..255 for defaults), combinational.
REQ-016 FSM states SHALL be IDLE, INT_RD, EXT_WAIT, EXT_DONE.
REQ-017 In IDLE with Wr=1 (Wr has priority over Rd when both are asserted) to an internal address: IntWe=1 in the same cycle, Stall=0, state remains IDLE (zero wait states).
REQ-018 In IDLE with Rd=1, Wr=0 to an internal address: Stall=1, next state INT_RD.
REQ-019 In INT_RD: RdData=IntRdData, Stall=0, next state IDLE (one wait state).
REQ-020 In IDLE with Rd or Wr to an external address: Stall=1; ExtAddr, ExtWrData and ExtWe (=Wr) registered; ExtReq=1 from the next cycle; next state EXT_WAIT.
REQ-021 In EXT_WAIT: Stall=1, ExtReq=1; on ExtAck=1, ExtRdData is latched into RdData, ExtReq drops next cycle, next state EXT_DONE.
REQ-022 In EXT_WAIT a counter SHALL increment each cycle; on reaching TIMEOUT without ExtAck: BusError=1 for one cycle, RdData=0, ExtReq drops, next state EXT_DONE.
REQ-023 ExtAck and TIMEOUT reached in the same cycle SHALL be treated as ack (no BusError).
REQ-024 In EXT_DONE: Stall=0, RdData holds the latched value, next state IDLE.
REQ-025 A new request SHALL be accepted only in IDLE; the request that was held through INT_RD or EXT_DONE SHALL be treated as consumed.
REQ-026 ExtAck outside EXT_WAIT SHALL be ignored.
REQ-027 IntWe SHALL be 0 in every state other than IDLE.

Reset
REQ-028 While Reset=1: state=IDLE, counter=0, and Stall, ExtReq, ExtWe, IntWe, BusError=0; RdData, ExtAddr and ExtWrData=0.
REQ-029 Reset asserted mid-transaction SHALL abort it immediately (ExtReq drops asynchronously); no completion SHALL be reported afterwards.

Structure
REQ-030 Package mem_bus_pkg SHALL hold the state encoding and the default INT_LOWER/INT_UPPER/TIMEOUT constants.
REQ-031 Window comparison SHALL be a sub-module addr_window_cmp (Address, lower, upper -> hit).

Verification
REQ-032 Wr=1, Address=32'h800, WrData=32'hA5A5A5A5 -> IntWe=1 and IntAddr=0 in the same cycle, Stall=0.
REQ-033 Rd=1, Address=32'hBFC, IntRdData=32'h1234 -> Stall=1 for 1 cycle, then RdData=32'h1234 with Stall=0.
REQ-034 Rd=1, Address=32'hC00, ExtAck asserted 3 cycles after ExtReq with ExtRdData=32'hDEADBEEF -> ExtAddr=32'hC00, RdData=32'hDEADBEEF in EXT_DONE, Stall=0 there.
REQ-035 Wr=1, Address=32'h7FC, ExtAck never asserted -> BusError pulse after 16 EXT_WAIT cycles, Stall released the cycle after.
REQ-036 Reset asserted during EXT_WAIT -> ExtReq=0 and Stall=0 immediately, state IDLE after release.
REQ-037 Rd=1 and Wr=1 both asserted at Address=32'h900 -> handled as write (IntWe=1), no read wait state.
